// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for an N-lane in-order MIPS pipeline. It provides E-stage and
// D-stage forward selects with cross-lane forwarding, and load-use, branch and
// multiplier stalls. A registered scoreboard tracks the single in-flight
// multi-cycle multiply.
//
// Parameters
//   LANES    issue lanes (1-4); lane k+1 is younger than lane k
//   AW       register-address width; register 0 always reads as zero
//   MULT_LAT multiplier latency in cycles (2-15)
//   FW       forward-select width (derived)
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   rsD, rtD                   D-stage sources, lane k at [k*AW +: AW]
//   rsE, rtE                   E-stage sources
//   WriteRegE/M/W              destination per lane per stage
//   RegWriteE/M/W              write enable per lane per stage
//   MemtoRegE/M                load in that stage/lane
//   BranchD                    branch in D per lane
//   MultD, MultE               multiply in D / E per lane
//   ForwardAE/BE               0 = regfile, 1+k = M lane k, 1+LANES+k = W lane k
//   ForwardAD/BD               0 = regfile, 1+k = M lane k
//   StallF, StallD, FlushE     pipeline controls (identical)
//   MultBusy, MultDone         multiplier in flight / final multiplier cycle
//   MultDst                    destination of the in-flight multiply
//   MultErr                    sticky flag: more than one multiply issued at once
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter  int LANES    = 2,
    parameter  int AW       = 5,
    parameter  int MULT_LAT = 4,
    localparam int FW       = $clog2(2*LANES+1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LANES*AW-1:0] rsD,
    input  logic [LANES*AW-1:0] rtD,
    input  logic [LANES*AW-1:0] rsE,
    input  logic [LANES*AW-1:0] rtE,
    input  logic [LANES*AW-1:0] WriteRegE,
    input  logic [LANES*AW-1:0] WriteRegM,
    input  logic [LANES*AW-1:0] WriteRegW,
    input  logic [LANES-1:0]    RegWriteE,
    input  logic [LANES-1:0]    RegWriteM,
    input  logic [LANES-1:0]    RegWriteW,
    input  logic [LANES-1:0]    MemtoRegE,
    input  logic [LANES-1:0]    MemtoRegM,
    input  logic [LANES-1:0]    BranchD,
    input  logic [LANES-1:0]    MultD,
    input  logic [LANES-1:0]    MultE,
    output logic [LANES*FW-1:0] ForwardAE,
    output logic [LANES*FW-1:0] ForwardBE,
    output logic [LANES*FW-1:0] ForwardAD,
    output logic [LANES*FW-1:0] ForwardBD,
    output logic                StallF,
    output logic                StallD,
    output logic                FlushE,
    output logic                MultBusy,
    output logic                MultDone,
    output logic [AW-1:0]       MultDst,
    output logic                MultErr
);

    logic [3:0]    r_count;
    logic [AW-1:0] r_mult_dst;
    logic          r_mult_err;

    logic          w_lwstall;
    logic          w_branchstall;
    logic          w_multstall;
    logic          w_stall;
    logic          w_issue;
    logic          w_multi_issue;
    logic [AW-1:0] w_issue_dst;

    // Forward selects. The W scan runs first and the M scan second so that
    // any M match overrides any W match; ascending lane order inside each scan
    // lets the youngest (highest) matching lane win.
    always_comb begin
        ForwardAE = '0;
        ForwardBE = '0;
        ForwardAD = '0;
        ForwardBD = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < LANES; k++) begin
                if (rsE[i*AW +: AW] != '0 && rsE[i*AW +: AW] == WriteRegW[k*AW +: AW] && RegWriteW[k])
                    ForwardAE[i*FW +: FW] = FW'(1 + LANES + k);
                if (rtE[i*AW +: AW] != '0 && rtE[i*AW +: AW] == WriteRegW[k*AW +: AW] && RegWriteW[k])
                    ForwardBE[i*FW +: FW] = FW'(1 + LANES + k);
            end
            for (int k = 0; k < LANES; k++) begin
                if (rsE[i*AW +: AW] != '0 && rsE[i*AW +: AW] == WriteRegM[k*AW +: AW] && RegWriteM[k])
                    ForwardAE[i*FW +: FW] = FW'(1 + k);
                if (rtE[i*AW +: AW] != '0 && rtE[i*AW +: AW] == WriteRegM[k*AW +: AW] && RegWriteM[k])
                    ForwardBE[i*FW +: FW] = FW'(1 + k);
                if (rsD[i*AW +: AW] != '0 && rsD[i*AW +: AW] == WriteRegM[k*AW +: AW] && RegWriteM[k])
                    ForwardAD[i*FW +: FW] = FW'(1 + k);
                if (rtD[i*AW +: AW] != '0 && rtD[i*AW +: AW] == WriteRegM[k*AW +: AW] && RegWriteM[k])
                    ForwardBD[i*FW +: FW] = FW'(1 + k);
            end
        end
    end

    // Stall detection across every D lane against every producer lane.
    always_comb begin
        w_lwstall     = 1'b0;
        w_branchstall = 1'b0;
        w_multstall   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < LANES; k++) begin
                // Load in E: its data is not available to D until after M.
                if (MemtoRegE[k] && RegWriteE[k]) begin
                    if (rsD[i*AW +: AW] != '0 && rsD[i*AW +: AW] == WriteRegE[k*AW +: AW])
                        w_lwstall = 1'b1;
                    if (rtD[i*AW +: AW] != '0 && rtD[i*AW +: AW] == WriteRegE[k*AW +: AW])
                        w_lwstall = 1'b1;
                end
                // Branch compares in D: an E-stage result or an M-stage load
                // cannot be forwarded into the comparator in time.
                if (BranchD[i]) begin
                    if ((RegWriteE[k] && rsD[i*AW +: AW] != '0 && rsD[i*AW +: AW] == WriteRegE[k*AW +: AW]) ||
                        (RegWriteE[k] && rtD[i*AW +: AW] != '0 && rtD[i*AW +: AW] == WriteRegE[k*AW +: AW]))
                        w_branchstall = 1'b1;
                    if ((MemtoRegM[k] && RegWriteM[k] && rsD[i*AW +: AW] != '0 && rsD[i*AW +: AW] == WriteRegM[k*AW +: AW]) ||
                        (MemtoRegM[k] && RegWriteM[k] && rtD[i*AW +: AW] != '0 && rtD[i*AW +: AW] == WriteRegM[k*AW +: AW]))
                        w_branchstall = 1'b1;
                end
            end
            // Data dependence on the in-flight multiply result.
            if (MultBusy) begin
                if (rsD[i*AW +: AW] != '0 && rsD[i*AW +: AW] == r_mult_dst)
                    w_multstall = 1'b1;
                if (rtD[i*AW +: AW] != '0 && rtD[i*AW +: AW] == r_mult_dst)
                    w_multstall = 1'b1;
            end
        end
        // Only one multiplier: a second multiply must wait for it to drain.
        if (MultBusy && (MultD != '0))
            w_multstall = 1'b1;
    end

    assign w_stall = w_lwstall | w_branchstall | w_multstall;
    assign StallF  = w_stall;
    assign StallD  = w_stall;
    assign FlushE  = w_stall;

    // Issue decode: lowest set lane supplies the destination. Clearing the
    // lowest set bit leaves a nonzero value only when two or more are set.
    assign w_issue       = (MultE != '0);
    assign w_multi_issue = ((MultE & (MultE - 1'b1)) != '0);

    always_comb begin
        w_issue_dst = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (MultE[k])
                w_issue_dst = WriteRegE[k*AW +: AW];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count    <= '0;
            r_mult_dst <= '0;
            r_mult_err <= 1'b0;
        end else begin
            if (w_issue) begin
                // A new issue wins even in the final cycle of the previous one.
                r_count    <= 4'(MULT_LAT);
                r_mult_dst <= w_issue_dst;
                if (w_multi_issue)
                    r_mult_err <= 1'b1;
            end else if (r_count != '0) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    assign MultBusy = (r_count != '0);
    assign MultDone = (r_count == 4'd1);
    assign MultDst  = r_mult_dst;
    assign MultErr  = r_mult_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int LANES    = 2;
  localparam int AW       = 5;
  localparam int MULT_LAT = 4;
  localparam int FW       = 3;

  logic                clk;
  logic                reset;
  logic [LANES*AW-1:0] rsD, rtD, rsE, rtE;
  logic [LANES*AW-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic [LANES-1:0]    RegWriteE, RegWriteM, RegWriteW;
  logic [LANES-1:0]    MemtoRegE, MemtoRegM;
  logic [LANES-1:0]    BranchD, MultD, MultE;
  logic [LANES*FW-1:0] ForwardAE, ForwardBE, ForwardAD, ForwardBD;
  logic                StallF, StallD, FlushE;
  logic                MultBusy, MultDone, MultErr;
  logic [AW-1:0]       MultDst;

  int n_pass;
  int n_total;
  int done_seen;

  hazard_scoreboard #(.LANES(LANES), .AW(AW), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .MultD(MultD), .MultE(MultE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .MultBusy(MultBusy), .MultDone(MultDone), .MultDst(MultDst), .MultErr(MultErr)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic clear_inputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = '0; RegWriteM = '0; RegWriteW = '0;
    MemtoRegE = '0; MemtoRegM = '0;
    BranchD = '0; MultD = '0; MultE = '0;
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    n_total++;
    if (MultBusy !== 1'b0) $display("FAIL reset_busy got %0b want 0", MultBusy); else n_pass++;
    n_total++;
    if (MultDone !== 1'b0) $display("FAIL reset_done got %0b want 0", MultDone); else n_pass++;
    n_total++;
    if (MultDst !== 5'd0) $display("FAIL reset_dst got %0d want 0", MultDst); else n_pass++;
    n_total++;
    if (MultErr !== 1'b0) $display("FAIL reset_err got %0b want 0", MultErr); else n_pass++;
    n_total++;
    if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== '0)
      $display("FAIL reset_fwd got %h want 0", {ForwardAE, ForwardBE, ForwardAD, ForwardBD}); else n_pass++;
    n_total++;
    if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL reset_stall got %b want 000", {StallF, StallD, FlushE}); else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fwd_e();
    clear_inputs();
    WriteRegM = {5'd8, 5'd8}; RegWriteM = 2'b11;
    WriteRegW = {5'd0, 5'd8}; RegWriteW = 2'b01;
    rsE = {5'd0, 5'd8};
    rtE = {5'd8, 5'd0};
    settle();
    n_total++;
    if (ForwardAE[2:0] !== 3'd2) $display("FAIL fwd_ae_m_lane1 got %0d want 2", ForwardAE[2:0]); else n_pass++;
    n_total++;
    if (ForwardBE[5:3] !== 3'd2) $display("FAIL fwd_be1_m_lane1 got %0d want 2", ForwardBE[5:3]); else n_pass++;
    // only W writers: W lane 0 -> 1+LANES+0 = 3
    RegWriteM = 2'b00;
    settle();
    n_total++;
    if (ForwardAE[2:0] !== 3'd3) $display("FAIL fwd_ae_w_lane0 got %0d want 3", ForwardAE[2:0]); else n_pass++;
    // both W lanes write reg 8 -> highest lane wins: 1+2+1 = 4
    WriteRegW = {5'd8, 5'd8}; RegWriteW = 2'b11;
    settle();
    n_total++;
    if (ForwardAE[2:0] !== 3'd4) $display("FAIL fwd_ae_w_lane1 got %0d want 4", ForwardAE[2:0]); else n_pass++;
    // M lane 0 only beats both W lanes -> 1
    RegWriteM = 2'b01;
    settle();
    n_total++;
    if (ForwardAE[2:0] !== 3'd1) $display("FAIL fwd_ae_m_beats_w got %0d want 1", ForwardAE[2:0]); else n_pass++;
    // source register 0 never forwards
    rsE = '0;
    WriteRegM = '0; RegWriteM = 2'b11;
    settle();
    n_total++;
    if (ForwardAE[2:0] !== 3'd0) $display("FAIL fwd_ae_zero_src got %0d want 0", ForwardAE[2:0]); else n_pass++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    MemtoRegE = 2'b10; RegWriteE = 2'b10;
    WriteRegE = {5'd5, 5'd0};
    rtD = {5'd0, 5'd5};
    settle();
    n_total++;
    if ({StallF, StallD, FlushE} !== 3'b111) $display("FAIL lwstall_on got %b want 111", {StallF, StallD, FlushE}); else n_pass++;
    MemtoRegE = 2'b00;
    settle();
    n_total++;
    if ({StallF, StallD, FlushE} !== 3'b000) $display("FAIL lwstall_off got %b want 000", {StallF, StallD, FlushE}); else n_pass++;
    n_total++;
    if (ForwardBD[2:0] !== 3'd0) $display("FAIL lw_fwd_bd got %0d want 0", ForwardBD[2:0]); else n_pass++;
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchD = 2'b10;
    rsD = {5'd3, 5'd0};
    WriteRegM = {5'd0, 5'd3}; RegWriteM = 2'b01;
    settle();
    n_total++;
    if (StallD !== 1'b0) $display("FAIL br_nostall got %0b want 0", StallD); else n_pass++;
    n_total++;
    if (ForwardAD[5:3] !== 3'd1) $display("FAIL br_fwd_ad1 got %0d want 1", ForwardAD[5:3]); else n_pass++;
    // E-stage ALU writer of reg 3 -> branch stall
    WriteRegE = {5'd0, 5'd3}; RegWriteE = 2'b01;
    settle();
    n_total++;
    if (StallF !== 1'b1) $display("FAIL br_e_stall got %0b want 1", StallF); else n_pass++;
    // M-stage load of reg 3 -> branch stall
    RegWriteE = 2'b00; MemtoRegM = 2'b01;
    settle();
    n_total++;
    if (FlushE !== 1'b1) $display("FAIL br_mload_stall got %0b want 1", FlushE); else n_pass++;
    // same hazards without BranchD -> no stall
    BranchD = 2'b00;
    settle();
    n_total++;
    if (StallD !== 1'b0) $display("FAIL br_nobranch got %0b want 0", StallD); else n_pass++;
  endtask

  task automatic test_mult_timing();
    clear_inputs();
    MultE = 2'b01; WriteRegE = {5'd0, 5'd9};
    tick();  // edge t
    MultE = 2'b00; WriteRegE = '0;
    rsD = {5'd0, 5'd9};
    settle();
    // cycle t+1
    n_total++;
    if ({MultBusy, MultDone} !== 2'b10) $display("FAIL mul_t1 busy/done got %b want 10", {MultBusy, MultDone}); else n_pass++;
    n_total++;
    if (MultDst !== 5'd9) $display("FAIL mul_dst got %0d want 9", MultDst); else n_pass++;
    n_total++;
    if (StallD !== 1'b1) $display("FAIL mul_dep_t1 got %0b want 1", StallD); else n_pass++;
    tick();
    // cycle t+2: structural hazard with no data dependence
    rsD = '0; MultD = 2'b10;
    settle();
    n_total++;
    if (StallD !== 1'b1) $display("FAIL mul_struct_t2 got %0b want 1", StallD); else n_pass++;
    MultD = 2'b00; rsD = {5'd0, 5'd9};
    tick();
    // cycle t+3
    n_total++;
    if ({MultBusy, MultDone, StallD} !== 3'b101) $display("FAIL mul_t3 got %b want 101", {MultBusy, MultDone, StallD}); else n_pass++;
    tick();
    // cycle t+4: final cycle, dependent still stalls
    n_total++;
    if ({MultBusy, MultDone, StallD} !== 3'b111) $display("FAIL mul_t4 got %b want 111", {MultBusy, MultDone, StallD}); else n_pass++;
    tick();
    // cycle t+5: released
    n_total++;
    if ({MultBusy, MultDone, StallD} !== 3'b000) $display("FAIL mul_t5 got %b want 000", {MultBusy, MultDone, StallD}); else n_pass++;
    n_total++;
    if (MultErr !== 1'b0) $display("FAIL mul_single_noerr got %0b want 0", MultErr); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    MultE = 2'b11; WriteRegE = {5'd13, 5'd12};
    tick();
    MultE = 2'b00; WriteRegE = '0;
    settle();
    n_total++;
    if (MultErr !== 1'b1) $display("FAIL dual_err got %0b want 1", MultErr); else n_pass++;
    n_total++;
    if (MultDst !== 5'd12) $display("FAIL dual_dst got %0d want 12", MultDst); else n_pass++;
    tick();
    tick();
    tick();
    // final cycle of first multiply; issue a new one now
    MultE = 2'b01; WriteRegE = {5'd0, 5'd14};
    settle();
    n_total++;
    if (MultDone !== 1'b1) $display("FAIL reissue_done got %0b want 1", MultDone); else n_pass++;
    tick();
    MultE = 2'b00; WriteRegE = '0;
    settle();
    n_total++;
    if ({MultBusy, MultDone} !== 2'b10) $display("FAIL reload_busy got %b want 10", {MultBusy, MultDone}); else n_pass++;
    n_total++;
    if (MultDst !== 5'd14) $display("FAIL reload_dst got %0d want 14", MultDst); else n_pass++;
    tick();
    tick();
    n_total++;
    if (MultDone !== 1'b0) $display("FAIL reload_cnt2 got %0b want 0", MultDone); else n_pass++;
    tick();
    // reload went to MULT_LAT, so done is 3 cycles after the reload cycle
    n_total++;
    if (MultDone !== 1'b1) $display("FAIL reload_done got %0b want 1", MultDone); else n_pass++;
    n_total++;
    if (MultErr !== 1'b1) $display("FAIL err_sticky got %0b want 1", MultErr); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    MultE = 2'b11; WriteRegE = {5'd7, 5'd6};
    tick();  // count 4
    MultE = 2'b00; WriteRegE = '0;
    tick();  // count 3
    tick();  // count 2
    settle();
    n_total++;
    if ({MultBusy, MultDone, MultErr} !== 3'b101) $display("FAIL pre_reset got %b want 101", {MultBusy, MultDone, MultErr}); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++;
    if ({MultBusy, MultDone, MultErr} !== 3'b000) $display("FAIL mid_reset got %b want 000", {MultBusy, MultDone, MultErr}); else n_pass++;
    n_total++;
    if (MultDst !== 5'd0) $display("FAIL mid_reset_dst got %0d want 0", MultDst); else n_pass++;
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (MultDone === 1'b1) done_seen++;
    end
    n_total++;
    if (done_seen !== 0) $display("FAIL abandoned_done got %0d pulses want 0", done_seen); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b0;
    clear_inputs();
    test_reset();
    test_fwd_e();
    test_load_use();
    test_branch();
    test_mult_timing();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout got no end want end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the N-lane in-order MIPS pipeline: generalises per-lane forwarding, load-use and branch stalls to LANES issue lanes with cross-lane forwarding. Adds a registered scoreboard for the multi-cycle multiplier so dependent and structurally conflicting instructions stall in D. Forwarding and stall outputs are combinational; multiplier tracking state is sequential. Sits beside the datapath, driving E-stage and D-stage forward muxes and the F/D/E pipeline-register controls.

## Interface
- LANES, 2, issue lanes (1–4); lane k+1 is younger than lane k in program order
- AW, 5, register-address width; register 0 is hard-wired zero
- MULT_LAT, 4, multiplier latency in cycles (2–15)
- FW, $clog2(2*LANES+1), forward-select width (derived, not overridden)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- rsD, rtD  in  LANES*AW  D-stage source registers, lane k at [k*AW +: AW]
- rsE, rtE  in  LANES*AW  E-stage source registers
- WriteRegE, WriteRegM, WriteRegW  in  LANES*AW  destination per lane per stage
- RegWriteE, RegWriteM, RegWriteW  in  LANES  write enable per lane per stage
- MemtoRegE, MemtoRegM  in  LANES  load in that stage/lane
- BranchD  in  LANES  branch in D
- MultD, MultE  in  LANES  multiply in D / E
- ForwardAE, ForwardBE  out  LANES*FW  E-operand select: 0 = register file, 1+k = M lane k, 1+LANES+k = W lane k
- ForwardAD, ForwardBD  out  LANES*FW  D branch-compare select: 0 or 1+k (M lane k only)
- StallF, StallD, FlushE  out  1  pipeline controls (all equal)
- MultBusy  out  1  count != 0
- MultDone  out  1  final multiplier cycle
- MultDst  out  AW  destination of the in-flight multiply
- MultErr  out  1  sticky illegal-issue flag

## Operation
- Operand match: source nonzero, equals destination, and that lane's write enable is set.
- E forwarding per lane and operand: any M match beats any W match; within a stage the highest matching lane wins; no match gives 0.
- D forwarding: same rule restricted to M stage.
- lwstall: any D-lane source matches WriteRegE[k] with MemtoRegE[k] & RegWriteE[k], for any k.
- branchstall: BranchD[i] and a lane-i source matches either an E-stage writer (RegWriteE) or an M-stage load (MemtoRegM & RegWriteM).
- multstall: MultBusy and any D-lane source equals MultDst (nonzero); or any MultD bit set while MultBusy (structural hazard).
- StallF = StallD = FlushE = lwstall | branchstall | multstall.
- Scoreboard registers: count (4 bits), MultDst, MultErr.
- Issue: any MultE bit set → count <= MULT_LAT, MultDst <= WriteRegE of lowest set lane.
- More than one MultE bit set → issue lowest lane, MultErr <= 1. MultErr clears only on reset.
- No issue and count != 0 → count decrements. MultDone = (count == 1).
- Issue in the MultDone cycle: the new load wins, and MultDone still asserts that cycle.
- Reset low at a clock edge: count = 0, MultDst = 0, MultErr = 0. Any in-flight multiply is abandoned with no MultDone.

## Timing
- Forward and stall outputs are combinational, valid in the same cycle as their inputs.
- A multiply in E at edge t gives MultBusy high for cycles t+1 … t+MULT_LAT, with MultDone in cycle t+MULT_LAT.
- The dependent D instruction stalls through cycle t+MULT_LAT and proceeds in t+MULT_LAT+1, when the product is available from writeback.
- Reset values: MultBusy 0, MultDone 0, MultDst 0, MultErr 0. With zero-valued data inputs, all Forward* are 0 and the stalls are 0.

## Test plan
- LANES=2; WriteRegM lane0 = 8, lane1 = 8, both RegWriteM; WriteRegW lane0 = 8; rsE lane0 = 8 → ForwardAE lane0 = 2 (M lane1). rsE = 0 with the same writers → ForwardAE = 0.
- Load in E lane1 with WriteRegE = 5; rtD lane0 = 5 → StallF/StallD/FlushE = 1. Drop MemtoRegE → stalls 0 and ForwardBD lane0 = 0.
- BranchD lane1, rsD lane1 = 3, WriteRegM lane0 = 3 with RegWriteM, no load → no stall, ForwardAD lane1 = 1.
- MULT_LAT=4: MultE lane0 with WriteRegE = 9 at edge t → MultBusy for 4 cycles, MultDone in t+4. rsD = 9 stalls through t+4 and releases at t+5. MultD in t+2 also stalls.
- MultE = 2'b11 → MultErr sets and stays set; MultDst = lane0 WriteRegE. Re-issue during the MultDone cycle → count reloads to 4.
- Reset low mid-count (count = 2) → next cycle MultBusy = 0, MultErr = 0, no MultDone pulse.
